bist_scan_sequencer: RTL and testbench

Phase sequencer for the scan-based BIST datapath: LFSR pattern sources, scan-chained circuit under test, MISR and signature comparator. After a start request it seeds the LFSRs, clears the MISR, and runs a fixed number of shift/capture patterns through the scan chain. It then flushes the chain, pulses the comparator's finish strobe and reports completion. It sits between the top-level BIST request pins and the LFSR/MISR/comparator instances, replacing the single scan-enable level with explicit per-phase controls.

---
 rtl/bist_scan_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_bist_scan_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bist_scan_sequencer.sv
// bist_scan_sequencer: phase sequencer for the scan-based BIST datapath.
// Sequence: seed LFSRs and clear the MISR, then run N_PATTERNS shift/capture
// rounds. After that it flushes the chain, strobes the comparator and reports
// completion.
// Optional feature macro: BIST_ABORT_EN. When it is defined, the abort input
// terminates an active run. Without it, abort is ignored and aborted stays 0.
// All control outputs are registered: they are decoded from the next state,
// so they change on the same edge as the state register.
module bist_scan_sequencer #(
    parameter int CHAIN_LEN  = 8,
    parameter int N_PATTERNS = 64
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            bist_start,
    input  logic                            abort,
    output logic                            scan_en,
    output logic                            test_sel,
    output logic                            seed_load,
    output logic                            misr_clr,
    output logic                            misr_en,
    output logic                            finish,
    output logic                            running,
    output logic                            bist_end,
    output logic                            aborted,
    output logic [$clog2(N_PATTERNS+1)-1:0] pattern_cnt
);

    localparam int PW = $clog2(N_PATTERNS + 1);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [PW-1:0] PAT_LAST   = PW'(N_PATTERNS);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_FLUSH   = 3'd4,
        S_COMPARE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Control bit order: {scan_en, test_sel, seed_load, misr_clr, misr_en,
    // finish, running, bist_end}.
    function automatic logic [7:0] decode_ctrl(input state_t s);
        logic [7:0] c;
        case (s)
            S_IDLE:    c = 8'b0000_0000;
            S_INIT:    c = 8'b0111_0010;
            S_SHIFT:   c = 8'b1100_1010;
            S_CAPTURE: c = 8'b0100_1010;
            S_FLUSH:   c = 8'b1100_1010;
            S_COMPARE: c = 8'b0000_0110;
            S_DONE:    c = 8'b0000_0001;
            default:   c = 8'b0000_0000;
        endcase
        return c;
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   shift_cnt_r;
    logic [CW-1:0]   shift_cnt_next_s;
    logic [PW-1:0]   pattern_cnt_r;
    logic [PW-1:0]   pattern_cnt_next_s;
    logic [PW-1:0]   pattern_inc_s;
    logic            aborted_r;
    logic            aborted_next_s;
    logic [7:0]      ctrl_r;
    logic            active_s;
    logic            abort_req_s;

    assign active_s = (state_r != S_IDLE) && (state_r != S_DONE);

`ifdef BIST_ABORT_EN
    assign abort_req_s = abort & active_s;
`else
    assign abort_req_s = abort & 1'b0;
`endif

    assign pattern_inc_s = pattern_cnt_r + PW'(1);

    // Next-state, counter and sticky-flag logic.
    always_comb begin
        next_state_s       = state_r;
        shift_cnt_next_s   = shift_cnt_r;
        pattern_cnt_next_s = pattern_cnt_r;
        aborted_next_s     = aborted_r;
        case (state_r)
            S_IDLE: begin
                if (bist_start) begin
                    next_state_s = S_INIT;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_INIT: begin
                next_state_s = S_SHIFT;
            end
            S_SHIFT: begin
                if (shift_cnt_r == SHIFT_LAST) begin
                    next_state_s     = S_CAPTURE;
                    shift_cnt_next_s = {CW{1'b0}};
                end else begin
                    shift_cnt_next_s = shift_cnt_r + CW'(1);
                end
            end
            S_CAPTURE: begin
                pattern_cnt_next_s = pattern_inc_s;
                if (pattern_inc_s == PAT_LAST) begin
                    next_state_s = S_FLUSH;
                end else begin
                    next_state_s = S_SHIFT;
                end
            end
            S_FLUSH: begin
                if (shift_cnt_r == SHIFT_LAST) begin
                    next_state_s     = S_COMPARE;
                    shift_cnt_next_s = {CW{1'b0}};
                end else begin
                    shift_cnt_next_s = shift_cnt_r + CW'(1);
                end
            end
            S_COMPARE: begin
                next_state_s = S_DONE;
            end
            S_DONE: begin
                if (bist_start) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase

        if (abort_req_s) begin
            next_state_s   = S_IDLE;
            aborted_next_s = 1'b1;
        end else begin
            aborted_next_s = aborted_next_s;
        end

        // Entering IDLE or INIT always starts from clean counters.
        if ((next_state_s == S_IDLE) || (next_state_s == S_INIT)) begin
            shift_cnt_next_s   = {CW{1'b0}};
            pattern_cnt_next_s = {PW{1'b0}};
        end else begin
            shift_cnt_next_s   = shift_cnt_next_s;
            pattern_cnt_next_s = pattern_cnt_next_s;
        end

        if (next_state_s == S_INIT) begin
            aborted_next_s = 1'b0;
        end else begin
            aborted_next_s = aborted_next_s;
        end
    end

    // State, counters, sticky flag and registered control outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= S_IDLE;
            shift_cnt_r   <= {CW{1'b0}};
            pattern_cnt_r <= {PW{1'b0}};
            aborted_r     <= 1'b0;
            ctrl_r        <= 8'b0000_0000;
        end else begin
            state_r       <= next_state_s;
            shift_cnt_r   <= shift_cnt_next_s;
            pattern_cnt_r <= pattern_cnt_next_s;
            aborted_r     <= aborted_next_s;
            ctrl_r        <= decode_ctrl(next_state_s);
        end
    end

    assign scan_en     = ctrl_r[7];
    assign test_sel    = ctrl_r[6];
    assign seed_load   = ctrl_r[5];
    assign misr_clr    = ctrl_r[4];
    assign misr_en     = ctrl_r[3];
    assign finish      = ctrl_r[2];
    assign running     = ctrl_r[1];
    assign bist_end    = ctrl_r[0];
    assign aborted     = aborted_r;
    assign pattern_cnt = pattern_cnt_r;

endmodule

// File: tb/tb_bist_scan_sequencer.sv
// Directed bench for bist_scan_sequencer. It drives a default instance
// (CHAIN_LEN=8, N_PATTERNS=64) and a minimum instance (1, 1).
// Flag vector order: {scan_en, test_sel, seed_load, misr_clr, misr_en,
// finish, running, bist_end, aborted}.
module tb_bist_scan_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       bist_start;
    logic       abort;
    logic       start_m;
    logic       abort_m;

    logic       scan_en, test_sel, seed_load, misr_clr, misr_en;
    logic       finish, running, bist_end, aborted;
    logic [6:0] pattern_cnt;

    logic       scan_en_m, test_sel_m, seed_load_m, misr_clr_m, misr_en_m;
    logic       finish_m, running_m, bist_end_m, aborted_m;
    logic [0:0] pattern_cnt_m;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [8:0] flags;
        int         cnt;
    } vec_t;

    vec_t main_tab [12];
    vec_t min_tab  [6];

    localparam logic [8:0] F_IDLE  = 9'b000000000;
    localparam logic [8:0] F_INIT  = 9'b011100100;
    localparam logic [8:0] F_SHIFT = 9'b110010100;
    localparam logic [8:0] F_CAPT  = 9'b010010100;
    localparam logic [8:0] F_CMP   = 9'b000001100;
    localparam logic [8:0] F_DONE  = 9'b000000010;
    localparam logic [8:0] F_ABRT  = 9'b000000001;

    bist_scan_sequencer dut (
        .CLK(CLK), .RST(RST), .bist_start(bist_start), .abort(abort),
        .scan_en(scan_en), .test_sel(test_sel), .seed_load(seed_load),
        .misr_clr(misr_clr), .misr_en(misr_en), .finish(finish),
        .running(running), .bist_end(bist_end), .aborted(aborted),
        .pattern_cnt(pattern_cnt)
    );

    bist_scan_sequencer #(.CHAIN_LEN(1), .N_PATTERNS(1)) dut_min (
        .CLK(CLK), .RST(RST), .bist_start(start_m), .abort(abort_m),
        .scan_en(scan_en_m), .test_sel(test_sel_m), .seed_load(seed_load_m),
        .misr_clr(misr_clr_m), .misr_en(misr_en_m), .finish(finish_m),
        .running(running_m), .bist_end(bist_end_m), .aborted(aborted_m),
        .pattern_cnt(pattern_cnt_m)
    );

    // Free-running clock, 10 time units per period.
    always #5 CLK = ~CLK;

    function automatic logic [8:0] flags_main();
        return {scan_en, test_sel, seed_load, misr_clr, misr_en,
                finish, running, bist_end, aborted};
    endfunction

    function automatic logic [8:0] flags_min();
        return {scan_en_m, test_sel_m, seed_load_m, misr_clr_m, misr_en_m,
                finish_m, running_m, bist_end_m, aborted_m};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int c,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    initial begin
        int idx;
        logic exp_scan;

        main_tab[0]  = '{1,   F_INIT,  0};
        main_tab[1]  = '{2,   F_SHIFT, 0};
        main_tab[2]  = '{9,   F_SHIFT, 0};
        main_tab[3]  = '{10,  F_CAPT,  0};
        main_tab[4]  = '{11,  F_SHIFT, 1};
        main_tab[5]  = '{19,  F_CAPT,  1};
        main_tab[6]  = '{577, F_CAPT,  63};
        main_tab[7]  = '{578, F_SHIFT, 64};
        main_tab[8]  = '{585, F_SHIFT, 64};
        main_tab[9]  = '{586, F_CMP,   64};
        main_tab[10] = '{587, F_DONE,  64};
        main_tab[11] = '{600, F_DONE,  64};

        min_tab[0] = '{1, F_INIT,  0};
        min_tab[1] = '{2, F_SHIFT, 0};
        min_tab[2] = '{3, F_CAPT,  0};
        min_tab[3] = '{4, F_SHIFT, 1};
        min_tab[4] = '{5, F_CMP,   1};
        min_tab[5] = '{6, F_DONE,  1};

        RST = 1'b1; bist_start = 1'b0; abort = 1'b0; start_m = 1'b0; abort_m = 1'b0;
        repeat (2) step();
        RST = 1'b0;

        // Reset/idle: everything quiet for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_flags", i, 32'(flags_main()), 32'(F_IDLE));
            check("idle_cnt", i, 32'(pattern_cnt), 32'd0);
            check("idle_flags_min", i, 32'(flags_min()), 32'(F_IDLE));
        end

        // Minimum configuration run.
        start_m = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            check("min_flags", c, 32'(flags_min()), 32'(min_tab[c-1].flags));
            check("min_cnt", c, 32'(pattern_cnt_m), 32'(min_tab[c-1].cnt));
        end
        start_m = 1'b0;
        step();
        check("min_back_idle", 7, 32'(flags_min()), 32'(F_IDLE));

        // Full default run, bist_start held high.
        bist_start = 1'b1;
        idx = 0;
        for (int c = 1; c <= 600; c++) begin
            step();
            if (c >= 2 && c <= 577) begin
                exp_scan = (((c - 2) % 9) < 8);
            end else if (c >= 578 && c <= 585) begin
                exp_scan = 1'b1;
            end else begin
                exp_scan = 1'b0;
            end
            check("scan_en", c, 32'(scan_en), 32'(exp_scan));
            check("seed_load", c, 32'(seed_load), 32'(c == 1));
            check("finish", c, 32'(finish), 32'(c == 586));
            if (idx < 12 && main_tab[idx].cyc == c) begin
                check("run_flags", c, 32'(flags_main()), 32'(main_tab[idx].flags));
                check("run_cnt", c, 32'(pattern_cnt), 32'(main_tab[idx].cnt));
                idx++;
            end
`ifndef BIST_ABORT_EN
            // abort must be ignored in this build.
            if (c == 300) begin
                abort = 1'b1;
            end else begin
                abort = 1'b0;
            end
`endif
        end
        abort = 1'b0;

        // Handshake: DONE held with bist_start high does not retrigger.
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_done", 601 + i, 32'(flags_main()), 32'(F_DONE));
        end
        bist_start = 1'b0;
        step();
        check("hs_idle_flags", 0, 32'(flags_main()), 32'(F_IDLE));
        check("hs_idle_cnt", 0, 32'(pattern_cnt), 32'd0);
        bist_start = 1'b1;
        step();
        check("hs_init", 1, 32'(flags_main()), 32'(F_INIT));

        // Mid-run reset at cycle 100.
        for (int c = 2; c <= 100; c++) begin
            step();
        end
        check("pre_rst_flags", 100, 32'(flags_main()), 32'(F_CAPT));
        check("pre_rst_cnt", 100, 32'(pattern_cnt), 32'd10);
        RST = 1'b1;
        step();
        check("rst_flags", 101, 32'(flags_main()), 32'(F_IDLE));
        check("rst_cnt", 101, 32'(pattern_cnt), 32'd0);
        RST = 1'b0;
        step();
        check("restart_flags", 1, 32'(flags_main()), 32'(F_INIT));
        check("restart_cnt", 1, 32'(pattern_cnt), 32'd0);

`ifdef BIST_ABORT_EN
        // Abort at cycle 300, then restart clears the sticky flag.
        for (int c = 2; c <= 300; c++) begin
            step();
        end
        abort = 1'b1;
        bist_start = 1'b0;
        step();
        check("abort_flags", 301, 32'(flags_main()), 32'(F_ABRT));
        check("abort_cnt", 301, 32'(pattern_cnt), 32'd0);
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_sticky", 302 + i, 32'(flags_main()), 32'(F_ABRT));
        end
        bist_start = 1'b1;
        step();
        check("abort_clear_init", 1, 32'(flags_main()), 32'(F_INIT));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
